// File: rtl/vadd_burst_scheduler.sv
// Splits one kernel transfer into AXI-style burst commands and caps bursts in flight.
// Pulses ctrl_done once every issued burst has reported completion.
//
// state | meaning
// IDLE  | waiting for ctrl_start
// ISSUE | presenting burst commands until all beats are issued
// DRAIN | all bursts issued, waiting for outstanding to reach 0
// DONE  | transfer complete, ctrl_done pulses on the following cycle
module vadd_burst_scheduler #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_SIZE_WIDTH      = 32,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_MAX_BURST_LEN   = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                   ap_clk,
    input  logic                                   ap_rst_n,
    input  logic                                   ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]                ctrl_addr,
    input  logic [C_SIZE_WIDTH-1:0]                ctrl_size,
    output logic                                   ctrl_busy,
    output logic                                   ctrl_done,
    output logic                                   cmd_valid,
    input  logic                                   cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]                cmd_addr,
    output logic [7:0]                             cmd_len,
    input  logic                                   cmp_valid,
    output logic [$clog2(C_MAX_OUTSTANDING):0]     outstanding,
    output logic                                   err_cmp
);

    localparam int BEAT_SHIFT = $clog2(C_BYTES_PER_BEAT);
    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_SIZE_WIDTH-1:0] remaining;
    logic [C_SIZE_WIDTH-1:0] total_beats;
    logic [OUT_W-1:0]        out_cnt;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [8:0]              burst;
    logic                    start_ok;
    logic                    at_limit;
    logic                    hs;
    logic                    cmp_ok;
    logic                    last_burst;

    // Partial last beat rounds up to a whole beat.
    assign total_beats = (ctrl_size >> BEAT_SHIFT)
                       + C_SIZE_WIDTH'(|ctrl_size[BEAT_SHIFT-1:0]);

    assign start_ok   = ctrl_start && (state == S_IDLE) && !busy_q;
    assign at_limit   = (out_cnt == OUT_W'(C_MAX_OUTSTANDING));
    assign burst      = (remaining > C_SIZE_WIDTH'(C_MAX_BURST_LEN)) ?
                        9'(C_MAX_BURST_LEN) : remaining[8:0];
    assign last_burst = (remaining == C_SIZE_WIDTH'(burst));

    // Valid depends only on registered state, so the limit check happens before presentation.
    assign cmd_valid  = (state == S_ISSUE) && !at_limit;
    assign hs         = cmd_valid && cmd_ready;
    assign cmp_ok     = cmp_valid && ((out_cnt != '0) || hs);

    assign cmd_addr    = addr_q;
    assign cmd_len     = (state == S_ISSUE) ? 8'(burst - 9'd1) : 8'd0;
    assign outstanding = out_cnt;
    assign ctrl_busy   = busy_q;
    assign ctrl_done   = done_q;
    assign err_cmp     = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (total_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hs && last_burst) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            addr_q    <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            addr_q    <= ctrl_addr;
            remaining <= total_beats;
        end else if (hs) begin
            addr_q    <= addr_q + (C_ADDR_WIDTH'(burst) << BEAT_SHIFT);
            remaining <= remaining - C_SIZE_WIDTH'(burst);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_cnt <= '0;
        end else begin
            case ({hs, cmp_ok})
                2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                2'b01:   out_cnt <= out_cnt - OUT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == S_DONE);
            // Busy stays up through the done pulse, which also blocks a restart in that cycle.
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            if (cmp_valid && (out_cnt == '0) && !hs) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vadd_burst_scheduler.sv
// Directed bench for vadd_burst_scheduler: vector table of whole transfers plus
// hand-written sequences for the outstanding limit, back-pressure, busy and reset cases.
module tb_vadd_burst_scheduler;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [63:0] ctrl_addr = '0;
    logic [31:0] ctrl_size = '0;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmp_valid = 1'b0;
    logic [4:0]  outstanding;
    logic        err_cmp;

    vadd_burst_scheduler dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ctrl_start  (ctrl_start),
        .ctrl_addr   (ctrl_addr),
        .ctrl_size   (ctrl_size),
        .ctrl_busy   (ctrl_busy),
        .ctrl_done   (ctrl_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmp_valid   (cmp_valid),
        .outstanding (outstanding),
        .err_cmp     (err_cmp)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] size;
        int          ncmd;
        logic [63:0] first_addr;
        logic [7:0]  first_len;
        logic [63:0] last_addr;
        logic [7:0]  last_len;
        int          lat;
    } vec_t;

    vec_t        vecs[7];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ncmd = 0;
    int          ndone = 0;
    int          first_hs_cyc = 0;
    int          mon_err = 0;
    int          lat;
    int          due[$];
    bit          auto_cmp = 1'b0;
    bit          done_seen = 1'b0;
    bit          busy_at_done = 1'b0;
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    logic [63:0] pa = '0;
    logic [7:0]  pl = '0;
    logic [63:0] first_addr, last_addr;
    logic [7:0]  first_len, last_len;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    endtask

    // Samples the cycle's handshakes just after the inputs settle, then advances one clock.
    task automatic tick();
        #1;
        if (pv && !pr && (!cmd_valid || cmd_addr !== pa || cmd_len !== pl)) mon_err++;
        if (outstanding > 5'd16) mon_err++;
        pv = cmd_valid; pr = cmd_ready; pa = cmd_addr; pl = cmd_len;
        if (cmd_valid && cmd_ready) begin
            ncmd++;
            if (ncmd == 1) begin
                first_addr = cmd_addr; first_len = cmd_len; first_hs_cyc = cyc;
            end
            last_addr = cmd_addr; last_len = cmd_len;
            if (auto_cmp) due.push_back(cyc + 10);
        end
        if (ctrl_done) begin
            done_seen = 1'b1; ndone++; busy_at_done = ctrl_busy;
        end
        @(negedge ap_clk);
        cyc++;
        ctrl_start = 1'b0;
        cmp_valid  = 1'b0;
        if (auto_cmp && due.size() > 0 && due[0] <= cyc) begin
            cmp_valid = 1'b1;
            void'(due.pop_front());
        end
    endtask

    task automatic start_xfer(input logic [63:0] a, input logic [31:0] s);
        ncmd = 0; ndone = 0; done_seen = 1'b0;
        ctrl_addr = a; ctrl_size = s; ctrl_start = 1'b1;
        start_cyc = cyc;
        tick();
    endtask

    task automatic wait_done(input int budget, output int l);
        l = 0;
        while (!done_seen && l < budget) begin
            l++;
            tick();
        end
        chk("done_reached", 64'(done_seen), 64'd1);
    endtask

    initial begin
        vecs[0] = '{64'h1000, 32'd8192, 2, 64'h1000, 8'd63, 64'h2000, 8'd63, -1};
        vecs[1] = '{64'h4000, 32'd100,  1, 64'h4000, 8'd1,  64'h4000, 8'd1,  -1};
        vecs[2] = '{64'h8000, 32'd0,    0, 64'h0,    8'd0,  64'h0,    8'd0,   2};
        vecs[3] = '{64'h40,   32'd1,    1, 64'h40,   8'd0,  64'h40,   8'd0,  -1};
        vecs[4] = '{64'h0,    32'd4160, 2, 64'h0,    8'd63, 64'h1000, 8'd0,  -1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_F000, 32'd8192, 2,
                    64'hFFFF_FFFF_FFFF_F000, 8'd63, 64'h0, 8'd63, -1};
        vecs[6] = '{64'h5000, 32'd65,   1, 64'h5000, 8'd1,  64'h5000, 8'd1,  -1};

        #2;
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy", 64'(ctrl_busy), 64'd0);
        chk("rst_done", 64'(ctrl_done), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err_cmp), 64'd0);
        chk("rst_cmd_len", 64'(cmd_len), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();

        // Whole transfers, ready high, completion 10 cycles after each command.
        auto_cmp = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            start_xfer(vecs[i].addr, vecs[i].size);
            wait_done(400, lat);
            chk($sformatf("v%0d_ncmd", i), 64'(ncmd), 64'(vecs[i].ncmd));
            if (vecs[i].ncmd > 0) begin
                chk($sformatf("v%0d_first_addr", i), first_addr, vecs[i].first_addr);
                chk($sformatf("v%0d_first_len", i), 64'(first_len), 64'(vecs[i].first_len));
                chk($sformatf("v%0d_last_addr", i), last_addr, vecs[i].last_addr);
                chk($sformatf("v%0d_last_len", i), 64'(last_len), 64'(vecs[i].last_len));
                chk($sformatf("v%0d_first_cmd_lat", i), 64'(first_hs_cyc - start_cyc), 64'd1);
            end
            if (vecs[i].lat >= 0) chk($sformatf("v%0d_done_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy_at_done), 64'd1);
            tick();
            chk($sformatf("v%0d_ndone", i), 64'(ndone), 64'd1);
            chk($sformatf("v%0d_busy_after", i), 64'(ctrl_busy), 64'd0);
            chk($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'd0);
        end

        // Outstanding limit: 20 bursts, completions withheld.
        auto_cmp = 1'b0;
        start_xfer(64'h0, 32'd81920);
        for (int i = 0; i < 30; i++) tick();
        chk("lim_ncmd", 64'(ncmd), 64'd16);
        chk("lim_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("lim_outstanding", 64'(outstanding), 64'd16);
        cmp_valid = 1'b1;
        tick();
        tick();
        chk("lim_17th_ncmd", 64'(ncmd), 64'd17);
        chk("lim_17th_addr", last_addr, 64'h10000);
        lat = 0;
        while (!done_seen && lat < 300) begin
            lat++;
            cmp_valid = (outstanding != 5'd0);
            tick();
        end
        chk("lim_done", 64'(done_seen), 64'd1);
        chk("lim_total_ncmd", 64'(ncmd), 64'd20);
        chk("lim_err", 64'(err_cmp), 64'd0);

        // Back-pressure hold, then handshake and completion in the same cycle.
        cmd_ready = 1'b0;
        start_xfer(64'h3000, 32'd8192);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 64'(cmd_valid), 64'd1);
            chk("hold_addr", cmd_addr, 64'h3000);
            chk("hold_len", 64'(cmd_len), 64'd63);
        end
        cmd_ready = 1'b1;
        tick();
        chk("bp_out_after_first", 64'(outstanding), 64'd1);
        cmp_valid = 1'b1;
        tick();
        chk("bp_out_hs_and_cmp", 64'(outstanding), 64'd1);
        chk("bp_ncmd", 64'(ncmd), 64'd2);
        chk("bp_second_addr", last_addr, 64'h4000);
        cmp_valid = 1'b1;
        tick();
        wait_done(50, lat);

        // Start while busy is ignored; completion in IDLE flags err_cmp.
        auto_cmp = 1'b1;
        start_xfer(64'h0, 32'd4096);
        ctrl_start = 1'b1; ctrl_addr = 64'h9000; ctrl_size = 32'd8192;
        tick();
        wait_done(100, lat);
        tick(); tick(); tick();
        chk("busy_start_ncmd", 64'(ncmd), 64'd1);
        chk("busy_start_addr", last_addr, 64'h0);
        chk("busy_start_idle", 64'(ctrl_busy), 64'd0);
        chk("idle_err_before", 64'(err_cmp), 64'd0);
        auto_cmp = 1'b0;
        cmp_valid = 1'b1;
        tick();
        chk("idle_err_after", 64'(err_cmp), 64'd1);
        chk("idle_outstanding", 64'(outstanding), 64'd0);

        // Async reset in the middle of ISSUE.
        start_xfer(64'h0, 32'd81920);
        tick(); tick(); tick();
        chk("mid_issue_active", 64'(cmd_valid), 64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("arst_cmd_addr", cmd_addr, 64'h0);
        chk("arst_cmd_len", 64'(cmd_len), 64'd0);
        chk("arst_outstanding", 64'(outstanding), 64'd0);
        chk("arst_busy", 64'(ctrl_busy), 64'd0);
        chk("arst_err", 64'(err_cmp), 64'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        due.delete();
        auto_cmp = 1'b1;
        start_xfer(64'h2000, 32'd100);
        wait_done(100, lat);
        chk("post_rst_ncmd", 64'(ncmd), 64'd1);
        chk("post_rst_addr", last_addr, 64'h2000);
        chk("post_rst_len", 64'(last_len), 64'd1);
        chk("post_rst_outstanding", 64'(outstanding), 64'd0);

        chk("handshake_monitor", 64'(mon_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
